// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
//
// Shared definitions for the serial-in / parallel-out deserializer:
//   - sipo_state_t : receive FSM states (S_DATA collects data bits, S_PAR
//                    samples the trailing even-parity bit when parity is built in)
//   - cnt_width()  : width of a bit counter that must hold 0..data_width
//
// Optional feature macro used by the files that import this package:
//   SIPO_DESERIALIZER_PARITY_EN
// -----------------------------------------------------------------------------
package sipo_pkg;

    typedef enum logic {
        S_DATA = 1'b0,
        S_PAR  = 1'b1
    } sipo_state_t;

    // Counter width able to represent every value from 0 up to data_width.
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// -----------------------------------------------------------------------------
// sipo_out_reg
//
// One-deep valid/ready holding register for assembled words. A word offered on
// i_load is captured when the register is free (empty, or being emptied by a
// handshake in this same cycle). Otherwise the word is dropped, the held word
// is kept, and o_overrun pulses for one cycle.
//
// Build option: SIPO_DESERIALIZER_PARITY_EN adds a parity-error flag that is
// captured together with the data and held alongside it.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   i_load     in   a completed word is offered this cycle
//   i_data     in   the offered word
//   i_err      in   parity error of the offered word (parity build only)
//   i_ready    in   consumer accepts the held word when o_valid && i_ready
//   o_data     out  held word, stable while o_valid is 1
//   o_valid    out  a word is held
//   o_overrun  out  one-cycle pulse: an offered word was dropped
//   o_err      out  parity error of the held word (parity build only)
// -----------------------------------------------------------------------------
module sipo_out_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
`ifdef SIPO_DESERIALIZER_PARITY_EN
    input  logic                  i_err,
`endif
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_overrun,
`ifdef SIPO_DESERIALIZER_PARITY_EN
    output logic                  o_err
`else
    output logic                  o_unused_tie
`endif
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_overrun;
    logic                  w_free;

    // The slot can take a new word when empty, or when the held word leaves
    // through a handshake on the same edge the new word arrives.
    assign w_free = !r_valid || i_ready;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_load && !w_free;
            if (i_load && w_free) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_DESERIALIZER_PARITY_EN
    logic r_err;

    // The flag follows the data: updated only when a word is actually loaded,
    // so a dropped word leaves the flag of the held word untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (i_load && w_free) begin
            r_err <= i_err;
        end
    end

    assign o_err = r_err;
`else
    assign o_unused_tie = 1'b0;
`endif

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
//
// Serial-in, parallel-out receiver. Samples ser_in on each ser_valid cycle,
// assembles DATA_WIDTH-bit words LSB-first (first bit lands in bit 0) and
// hands each completed word to a one-deep valid/ready output register.
// flush aborts the partial word and wins over a completing bit in the same
// cycle. All outputs come straight from flops.
//
// Build option: SIPO_DESERIALIZER_PARITY_EN
//   defined   : each word is followed by one even-parity bit, sampled in S_PAR;
//               delivery happens on the parity-bit cycle and parity_err is
//               registered with the word.
//   undefined : no parity bit, no parity_err port; delivery on the last data bit.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   ser_in      in   serial data bit
//   ser_valid   in   ser_in is sampled this cycle
//   flush       in   synchronous abort of the partially assembled word
//   out_data    out  assembled word, stable while out_valid is 1
//   out_valid   out  a word is held in the output register
//   out_ready   in   consumer accepts the word when out_valid && out_ready
//   overrun     out  one-cycle pulse: a completed word was dropped
//   parity_err  out  parity error of the held word (parity build only)
// -----------------------------------------------------------------------------
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ser_in,
    input  logic                  ser_valid,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef SIPO_DESERIALIZER_PARITY_EN
    output logic                  overrun,
    output logic                  parity_err
`else
    output logic                  overrun
`endif
);

    localparam int              CW       = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DATA_WIDTH - 1);

    sipo_state_t           r_state;
    sipo_state_t           w_state_next;
    logic [DATA_WIDTH-1:0] r_sr;
    logic [DATA_WIDTH-1:0] w_sr_next;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_next;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_word;
`ifdef SIPO_DESERIALIZER_PARITY_EN
    logic                  w_perr;
`else
    logic                  w_unused_tie;
`endif

    // Next-state logic for the receive path.
    // NOTE: every signal gets a default before any branch, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_sr_next    = r_sr;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        w_word       = r_sr;
`ifdef SIPO_DESERIALIZER_PARITY_EN
        w_perr       = 1'b0;
`endif

        if (flush) begin
            // Abort wins over any bit arriving this cycle; the shift register
            // is left as is because the next word overwrites it completely.
            w_state_next = S_DATA;
            w_cnt_next   = '0;
        end else if (ser_valid) begin
            case (r_state)
                S_DATA: begin
                    w_sr_next = {ser_in, r_sr[DATA_WIDTH-1:1]};
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_next = '0;
`ifdef SIPO_DESERIALIZER_PARITY_EN
                        w_state_next = S_PAR;
`else
                        w_load = 1'b1;
                        w_word = w_sr_next;
`endif
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
`ifdef SIPO_DESERIALIZER_PARITY_EN
                S_PAR: begin
                    // r_sr already holds the full word; ser_in is the parity bit.
                    // Even parity: data bits plus parity bit must XOR to 0.
                    w_load       = 1'b1;
                    w_word       = r_sr;
                    w_perr       = (^r_sr) ^ ser_in;
                    w_state_next = S_DATA;
                end
`endif
                default: begin
                    w_state_next = S_DATA;
                end
            endcase
        end
    end

    // NOTE: the shift register is reset along with the counter and state; it is
    // a handful of flops, and clearing it keeps its contents defined after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_DATA;
            r_sr    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_sr    <= w_sr_next;
            r_cnt   <= w_cnt_next;
        end
    end

    sipo_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_load),
        .i_data       (w_word),
`ifdef SIPO_DESERIALIZER_PARITY_EN
        .i_err        (w_perr),
`endif
        .i_ready      (out_ready),
        .o_data       (out_data),
        .o_valid      (out_valid),
        .o_overrun    (overrun),
`ifdef SIPO_DESERIALIZER_PARITY_EN
        .o_err        (parity_err)
`else
        .o_unused_tie (w_unused_tie)
`endif
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// -----------------------------------------------------------------------------
// tb_sipo_deserializer
//
// Self-checking bench for sipo_deserializer (DATA_WIDTH = 8). The stimulus
// process drives one cycle at a time and feeds a bit-list reference model that
// pushes each delivered word (or the cycle of an expected overrun pulse) into
// queues. An independent negedge monitor compares out_valid, out_data,
// parity_err and overrun against the queue fronts and pops on handshakes.
// Build with +define+SIPO_DESERIALIZER_PARITY_EN to exercise the parity variant.
// -----------------------------------------------------------------------------
module tb_sipo_deserializer;

    localparam int W = 8;
`ifdef SIPO_DESERIALIZER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         ser_in;
    logic         ser_valid;
    logic         flush;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         overrun;
`ifdef SIPO_DESERIALIZER_PARITY_EN
    logic         parity_err;
`endif

    sipo_deserializer #(
        .DATA_WIDTH (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef SIPO_DESERIALIZER_PARITY_EN
        .overrun    (overrun),
        .parity_err (parity_err)
`else
        .overrun    (overrun)
`endif
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------ model
    typedef struct {
        logic [W-1:0] data;
        logic         perr;
        int           vis;   // first cycle the word should be visible
    } exp_t;

    exp_t exp_q[$];
    int   ovr_q[$];
    bit   cur[$];            // bits of the word currently being received
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Consequences of the coming clock edge, computed from the current inputs.
    function automatic void model_step();
        bit full;
        full = (exp_q.size() > 0);
        if (flush) begin
            cur.delete();
        end else if (ser_valid) begin
            cur.push_back(ser_in);
            if (cur.size() == NB) begin
                exp_t         e;
                logic [W-1:0] w;
                logic         p;
                w = '0;
                p = 1'b0;
                for (int i = 0; i < W; i++) w[i] = cur[i];
                for (int i = 0; i < NB; i++) p ^= cur[i];
                e.data = w;
                e.perr = p;
                e.vis  = cyc + 1;
                if (!full || out_ready) exp_q.push_back(e);
                else                    ovr_q.push_back(cyc + 1);
                cur.delete();
            end
        end
    endfunction

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        bit ev;
        bit eo;
        ev = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
        check("out_valid", out_valid, ev);
        if (ev) begin
            check("out_data", out_data, exp_q[0].data);
`ifdef SIPO_DESERIALIZER_PARITY_EN
            check("parity_err", parity_err, exp_q[0].perr);
`endif
            if (out_ready && reset) void'(exp_q.pop_front());
        end
        eo = (ovr_q.size() > 0) && (ovr_q[0] == cyc);
        check("overrun", overrun, eo);
        if (eo) void'(ovr_q.pop_front());
    end

    // -------------------------------------------------------------- stimulus
    task automatic drive(input logic v, input logic d, input logic f, input logic r);
        ser_valid = v;
        ser_in    = d;
        flush     = f;
        out_ready = r;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, r);
    endtask

    task automatic send_bits(input logic [32:0] bits, input int n, input int gap, input logic r);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, bits[i], 1'b0, r);
            if (i < n - 1) idle(gap, r);
        end
    endtask

    // Word plus, in the parity build, a correct even-parity bit.
    task automatic send_word(input logic [7:0] w, input int gap, input logic r);
        logic [32:0] b;
        b      = '0;
        b[7:0] = w;
        b[8]   = ^w;
        send_bits(b, NB, gap, r);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        cur.delete();
        exp_q.delete();
        ovr_q.delete();
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, '0);
        check("rst_overrun", overrun, 1'b0);
`ifdef SIPO_DESERIALIZER_PARITY_EN
        check("rst_parity_err", parity_err, 1'b0);
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [32:0] b;
        reset     = 1'b0;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        apply_reset();
        idle(2, 1'b1);

        // Basic word
        send_word(8'hA5, 0, 1'b1);
        check("basic_valid", out_valid, 1'b1);
        check("basic_data", out_data, 8'hA5);
        idle(2, 1'b1);

        // Same word with 3-cycle gaps between bits
        send_word(8'hA5, 3, 1'b1);
        check("gap_valid", out_valid, 1'b1);
        check("gap_data", out_data, 8'hA5);
        idle(2, 1'b1);

        // Overrun: second word dropped while the first is held
        send_word(8'h3C, 0, 1'b0);
        send_word(8'hC3, 0, 1'b0);
        check("ovr_pulse", overrun, 1'b1);
        check("ovr_hold", out_data, 8'h3C);
        idle(1, 1'b0);
        check("ovr_single", overrun, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);
        check("ovr_drained", out_valid, 1'b0);

        // Flush: after 5 bits, and coincident with the 8th bit
        b = 33'h0_0000_00FF;
        send_bits(b, 5, 0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        send_bits(b, 7, 0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        idle(1, 1'b1);
        check("flush_none", out_valid, 1'b0);
        send_word(8'h0F, 0, 1'b0);
        check("flush_data", out_data, 8'h0F);
        idle(2, 1'b1);

        // Reset mid-stream with a word held and a partial word in flight
        send_word(8'h99, 0, 1'b0);
        send_bits(b, 3, 0, 1'b0);
        apply_reset();
        send_word(8'h5A, 0, 1'b0);
        check("post_rst_data", out_data, 8'h5A);
        idle(2, 1'b1);

`ifdef SIPO_DESERIALIZER_PARITY_EN
        // Parity: correct and wrong parity bit
        b = 33'h1_07;
        send_bits(b, 9, 0, 1'b1);
        check("par_ok", parity_err, 1'b0);
        b = 33'h0_07;
        send_bits(b, 9, 0, 1'b1);
        check("par_bad", parity_err, 1'b1);
        check("par_bad_data", out_data, 8'h07);
        idle(2, 1'b1);
`endif

        // Random traffic: consumer mostly ready, then mostly stalled
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 49) == 0,
                  $urandom_range(0, 9) < 6);
        for (int i = 0; i < 2000; i++)
            drive($urandom_range(0, 9) < 8, 1'($urandom), $urandom_range(0, 79) == 0,
                  $urandom_range(0, 9) < 1);
        // Back-to-back words with out_ready held high
        for (int i = 0; i < 40 * NB; i++)
            drive(1'b1, 1'($urandom), 1'b0, 1'b1);
        idle(NB + 4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
